// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package instr_loader_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned WORD_W         = 32;

   typedef enum logic [2:0] {
      StIdle,
      StCollect,
      StWrite,
      StDrain,
      StFinish
   } loader_state_t;

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Packs a byte stream little-endian into 32-bit words and tracks the byte index.
module word_assembler
   import instr_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              clr,
   input  logic [7:0]        byte_data,
   output logic [WORD_W-1:0] word,
   output logic [1:0]        idx,
   output logic              full
);

   logic [WORD_W-1:0] word_q, word_d;
   logic [1:0]        idx_q, idx_d;

   always_comb begin
      word_d = word_q;
      idx_d  = idx_q;
      if (clr) begin
         word_d = '0;
         idx_d  = '0;
      end else if (load) begin
         word_d[8*idx_q +: 8] = byte_data;
         idx_d                = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
         idx_q  <= '0;
      end else begin
         word_q <= word_d;
         idx_q  <= idx_d;
      end
   end

   // High while the byte being loaded completes the word.
   assign full = load && !clr && (idx_q == 2'(BYTES_PER_WORD - 1));
   assign word = word_q;
   assign idx  = idx_q;

endmodule

// File: rtl/instr_loader.sv
// Streams a byte-wide program image into instruction memory while holding the CPU in reset.
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter  int unsigned DEPTH     = 1024,
   parameter  int unsigned BASE_ADDR = 0,
   parameter  int unsigned AW        = 32,
   localparam int unsigned CW        = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   input  logic              byte_last,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [AW-1:0]     wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CW-1:0]     word_count
);

   loader_state_t     state_q, state_d;
   logic [AW-1:0]     ptr_q, ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              last_q, last_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;

   logic              accept;
   logic              asm_load;
   logic              asm_clr;
   logic [WORD_W-1:0] asm_word;
   logic [1:0]        asm_idx;
   logic              asm_full;
   logic [CW-1:0]     cnt_inc;

   assign accept   = byte_valid && ready_q;
   assign asm_load = (state_q == StCollect) && accept;
   assign asm_clr  = (state_q == StIdle) && start;
   assign cnt_inc  = cnt_q + CW'(1);

   word_assembler u_asm (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (asm_load),
      .clr       (asm_clr),
      .byte_data (byte_data),
      .word      (asm_word),
      .idx       (asm_idx),
      .full      (asm_full)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      last_d  = last_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StCollect;
               err_d   = 1'b0;
               cnt_d   = '0;
               ptr_d   = AW'(BASE_ADDR);
               last_d  = 1'b0;
            end
         end
         StCollect: begin
            if (accept) begin
               if (asm_full) begin
                  state_d = StWrite;
                  last_d  = byte_last;
               end else if (byte_last && (asm_idx != 2'(BYTES_PER_WORD - 1))) begin
                  // Image ended mid-word: the partial word is dropped.
                  err_d   = 1'b1;
                  state_d = StFinish;
               end
            end
         end
         StWrite: begin
            ptr_d = ptr_q + AW'(BYTES_PER_WORD);
            cnt_d = cnt_inc;
            if (last_q) begin
               state_d = StFinish;
            end else if (cnt_inc == CW'(DEPTH)) begin
               state_d = StDrain;
            end else begin
               state_d = StCollect;
            end
         end
         StDrain: begin
            if (accept) begin
               err_d = 1'b1;
               if (byte_last) begin
                  state_d = StFinish;
               end
            end
         end
         StFinish: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      ready_d = (state_d == StCollect) || (state_d == StDrain);
      busy_d  = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         ptr_q   <= AW'(BASE_ADDR);
         cnt_q   <= '0;
         err_q   <= 1'b0;
         last_q  <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         last_q  <= last_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   // Address and data are forced to zero outside the write cycle.
   assign wr_en      = (state_q == StWrite);
   assign wr_addr    = wr_en ? ptr_q : '0;
   assign wr_data    = wr_en ? asm_word : '0;
   assign done       = (state_q == StFinish);
   assign byte_ready = ready_q;
   assign busy       = busy_q;
   assign cpu_rst    = busy_q;
   assign err        = err_q;
   assign word_count = cnt_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader built with DEPTH=2 so the overflow path is reachable.
module tb_instr_loader;

   localparam int unsigned DEPTH = 2;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_last;
   logic          byte_ready;
   logic          wr_en;
   logic [31:0]   wr_addr;
   logic [31:0]   wr_data;
   logic          cpu_rst;
   logic          busy;
   logic          done;
   logic          err;
   logic [CW-1:0] word_count;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [31:0]   wr_addr_q[$];
   logic [31:0]   wr_data_q[$];

   instr_loader #(
      .DEPTH     (DEPTH),
      .BASE_ADDR (0),
      .AW        (32)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_last  (byte_last),
      .byte_ready (byte_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .cpu_rst    (cpu_rst),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Write log; byte_ready must be low in every write cycle.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         wr_addr_q.push_back(wr_addr);
         wr_data_q.push_back(wr_data);
         check_eq("ready low in write", {63'd0, byte_ready}, 64'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last, inout int stalls);
      byte_valid = 1'b1;
      byte_data  = b;
      byte_last  = last;
      while (byte_ready !== 1'b1 && stalls < 20) begin
         tick();
         stalls++;
      end
      if (byte_ready !== 1'b1) begin
         check_eq("byte_ready timeout", {63'd0, byte_ready}, 64'd1);
      end
      tick();
   endtask

   task automatic send_word(input logic [31:0] w, input logic last, output int stalls);
      stalls = 0;
      for (int i = 0; i < 4; i++) begin
         send_byte(w[8*i +: 8], last && (i == 3), stalls);
      end
   endtask

   task automatic start_session();
      wr_addr_q.delete();
      wr_data_q.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("busy after start", {62'd0, busy, cpu_rst}, 64'd3);
   endtask

   // Waits for done, then confirms the CPU is released the cycle after.
   task automatic wait_done(output int waited);
      waited     = 0;
      byte_valid = 1'b0;
      byte_last  = 1'b0;
      while (done !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      check_eq("done pulse", {63'd0, done}, 64'd1);
      check_eq("cpu_rst at done", {63'd0, cpu_rst}, 64'd1);
      tick();
      check_eq("released after done", {61'd0, cpu_rst, busy, done}, 64'd0);
   endtask

   initial begin
      int st;
      int wt;
      rst_n      = 1'b0;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      byte_last  = 1'b0;
      #3;
      check_eq("reset ctrl outs", {58'd0, byte_ready, wr_en, cpu_rst, busy, done, err}, 64'd0);
      check_eq("reset addr/data", {wr_addr, wr_data}, 64'd0);
      check_eq("reset word_count", 64'(word_count), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Single addi word
      start_session();
      send_word(32'h0050_0093, 1'b1, st);
      wait_done(wt);
      check_eq("t1 word_count", 64'(word_count), 64'd1);
      check_eq("t1 err", {63'd0, err}, 64'd0);
      check_eq("t1 writes", 64'(wr_addr_q.size()), 64'd1);
      check_eq("t1 wr", {wr_addr_q[0], wr_data_q[0]}, {32'h0, 32'h0050_0093});

      // Two words back-to-back
      start_session();
      send_word(32'h0050_0093, 1'b0, st);
      check_eq("t2 stall w1", 64'(st), 64'd0);
      send_word(32'hFE00_9EE3, 1'b1, st);
      check_eq("t2 stall w2", 64'(st), 64'd1);
      wait_done(wt);
      check_eq("t2 writes", 64'(wr_addr_q.size()), 64'd2);
      check_eq("t2 wr0", {wr_addr_q[0], wr_data_q[0]}, {32'h0, 32'h0050_0093});
      check_eq("t2 wr1", {wr_addr_q[1], wr_data_q[1]}, {32'h4, 32'hFE00_9EE3});
      check_eq("t2 word_count", 64'(word_count), 64'd2);
      check_eq("t2 err", {63'd0, err}, 64'd0);

      // Partial word
      start_session();
      st = 0;
      send_byte(8'h13, 1'b0, st);
      send_byte(8'h00, 1'b1, st);
      wait_done(wt);
      check_eq("t3 done latency", 64'(wt), 64'd0);
      check_eq("t3 writes", 64'(wr_addr_q.size()), 64'd0);
      check_eq("t3 err", {63'd0, err}, 64'd1);
      check_eq("t3 word_count", 64'(word_count), 64'd0);

      // Overflow past DEPTH=2
      start_session();
      check_eq("t4 err cleared", {63'd0, err}, 64'd0);
      send_word(32'h0050_0093, 1'b0, st);
      send_word(32'hFE00_9EE3, 1'b0, st);
      check_eq("t4 err before drain", {63'd0, err}, 64'd0);
      st = 0;
      send_byte(8'h44, 1'b0, st);
      check_eq("t4 stall b9", 64'(st), 64'd1);
      check_eq("t4 err on b9", {63'd0, err}, 64'd1);
      send_byte(8'h33, 1'b0, st);
      send_byte(8'h22, 1'b0, st);
      send_byte(8'h11, 1'b1, st);
      check_eq("t4 stall b10-12", 64'(st), 64'd1);
      wait_done(wt);
      check_eq("t4 done latency", 64'(wt), 64'd0);
      check_eq("t4 writes", 64'(wr_addr_q.size()), 64'd2);
      check_eq("t4 wr addrs", {wr_addr_q[0], wr_addr_q[1]}, {32'h0, 32'h4});
      check_eq("t4 word_count", 64'(word_count), 64'd2);
      check_eq("t4 err", {63'd0, err}, 64'd1);

      // Asynchronous reset mid-session
      start_session();
      st = 0;
      send_byte(8'hAA, 1'b0, st);
      send_byte(8'hBB, 1'b0, st);
      byte_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t5 async reset outs",
               {58'd0, byte_ready, wr_en, cpu_rst, busy, done, err}, 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_eq("t5 no write", 64'(wr_addr_q.size()), 64'd0);
      start_session();
      send_word(32'h0000_0013, 1'b1, st);
      wait_done(wt);
      check_eq("t5 writes", 64'(wr_addr_q.size()), 64'd1);
      check_eq("t5 wr", {wr_addr_q[0], wr_data_q[0]}, {32'h0, 32'h0000_0013});

      // Ignored start and bytes offered in idle
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      byte_last  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
      end
      check_eq("t6 idle ignores bytes", {61'd0, byte_ready, busy, done}, 64'd0);
      byte_valid = 1'b0;
      byte_last  = 1'b0;
      start_session();
      st = 0;
      send_byte(8'hE3, 1'b0, st);
      send_byte(8'h9E, 1'b0, st);
      byte_valid = 1'b0;
      start      = 1'b1;
      tick();
      start = 1'b0;
      check_eq("t6 start ignored", {62'd0, busy, byte_ready}, 64'd3);
      send_byte(8'h00, 1'b0, st);
      send_byte(8'hFE, 1'b1, st);
      wait_done(wt);
      check_eq("t6 writes", 64'(wr_addr_q.size()), 64'd1);
      check_eq("t6 wr", {wr_addr_q[0], wr_data_q[0]}, {32'h0, 32'hFE00_9EE3});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Streams a program image into instruction memory, one byte at a time, before the CPU runs.
- Accepts bytes over a valid/ready interface and assembles them little-endian into 32-bit instruction words.
- Writes each word to the instruction-memory write port at consecutive word-aligned addresses.
- Holds the CPU in reset for the whole session, so the control unit only ever decodes a complete, consistent program.

Parameters:
DEPTH, 1024, instruction-memory capacity in 32-bit words (power of two)
BASE_ADDR, 0, byte address of the first word written (word-aligned)
AW, 32, width of wr_addr in bits

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a load session; sampled only in IDLE
byte_valid  input  1  byte_data is valid
byte_data  input  8  stream byte
byte_last  input  1  qualifies the final byte of the image; meaningful only when byte_valid=1
byte_ready  output  1  loader accepts the byte this cycle
wr_en  output  1  instruction-memory write strobe, one cycle per word
wr_addr  output  AW  byte address of the word being written
wr_data  output  32  assembled instruction word
cpu_rst  output  1  holds the CPU in reset while high
busy  output  1  session in progress
done  output  1  one-cycle pulse at session end
err  output  1  sticky error flag; cleared by the next start
word_count  output  $clog2(DEPTH)+1  words written in the current or last session

Behaviour:
- Reset: clk and rst_n as named above; reset is asynchronous, active-low. On reset all outputs are 0, state=IDLE, address pointer=BASE_ADDR, byte index=0, partial word discarded, no write issued. This applies when reset lands mid-session too.
- Handshake: a byte transfers on a rising edge with byte_valid && byte_ready. byte_ready is registered, and is high only in COLLECT and DRAIN.
- States: IDLE, COLLECT, WRITE, DRAIN, FINISH.
- IDLE:
  - start=1 -> COLLECT.
  - On entry to COLLECT: err<=0, word_count<=0, ptr<=BASE_ADDR, idx<=0.
- COLLECT:
  - An accepted byte goes into bits [8*idx+7:8*idx]; idx increments mod 4.
  - 4th byte (idx=3) accepted -> WRITE.
  - byte_last on byte idx 0..2 -> partial word: err<=1, word not written -> FINISH.
- WRITE:
  - Exactly one cycle: wr_en=1, wr_addr=ptr, wr_data=assembled word. byte_ready=0.
  - Next cycle: ptr+=4 and word_count+=1.
  - If that 4th byte carried byte_last -> FINISH.
  - Else if word_count (after increment) == DEPTH -> DRAIN.
  - Else -> COLLECT.
- DRAIN:
  - Memory full and more bytes are arriving: err<=1 on the first discarded byte.
  - Accepts and discards bytes until byte_last is accepted -> FINISH.
- FINISH: done=1 for one cycle -> IDLE.
- cpu_rst = busy = (state != IDLE). Both are registered from the next-state logic, so they rise the cycle after start is sampled.
- start while not IDLE: ignored.
- Latency: 4th byte handshake at edge N -> wr_en high in cycle N+1 -> byte_ready high again in cycle N+2.
- Addresses: ptr wraps only through reset or a new session, never in normal operation.
- A word is never written after a reset that occurs before its WRITE cycle.

Decomposition:
- Package instr_loader_pkg holds:
  - loader_state_t enum (IDLE, COLLECT, WRITE, DRAIN, FINISH)
  - BYTES_PER_WORD=4
  - WORD_W=32
- Sub-module word_assembler:
  - Inputs: clk, rst_n, load, clr, byte_data.
  - Outputs: word[31:0], idx[1:0], full.
  - Little-endian byte packing and index counter.
- instr_loader holds the FSM, address pointer and word counter.

Test Plan:
- addi x1,x0,5 image: start; bytes 93,00,50,00 with last on 00 -> one wr_en, wr_addr=0, wr_data=0x00500093; done pulse; word_count=1; err=0; cpu_rst high from the cycle after start until done.
- Two words (0x00500093, 0xFE009EE3 bne) sent back-to-back with byte_valid held high -> writes to addr 0 and 4; byte_ready low exactly in each WRITE cycle; word_count=2.
- Partial word: bytes 13,00 with last on the 2nd byte -> no wr_en; err=1; done pulse; word_count=0.
- Overflow with DEPTH=2: 3 words, last on byte 12 -> writes at 0 and 4 only; bytes 9-12 accepted and discarded; err=1; done on the cycle after byte 12.
- Reset mid-session: assert rst_n=0 after 2 bytes of word 1 -> all outputs 0 immediately (asynchronous) and no write. Then a fresh start plus a full word -> written at addr 0.
- start pulsed during COLLECT, and byte_valid asserted in IDLE -> ignored; byte_ready=0 in IDLE; no state change.
